fault_latch_nch: RTL and testbench

- Parametrised N-channel fault debounce/latch/aggregation unit for the H-bridge power unit control board.
- Successor to the fixed-width fault detector. Adds per-channel masking, a programmable debounce time, first-fault capture, a trip counter and a timed bypass request.
- Sits between the raw protection inputs (IGBT ERR, DCOV/DCUV, soft OV/UV, HOT) and pwm_out / fiber_tx.

---
 rtl/fault_latch_nch.sv | 140 ++++++++++++++
 tb/tb_fault_latch_nch.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fault_latch_nch.sv
// N-channel fault debounce, latch and aggregation for the H-bridge power unit.
// Each unmasked fault must be held for dly_us microsecond ticks before it latches.
// The first latch trips the unit and records which channel caused it.
// A trip that lasts BYP_DLY_US ticks raises a sticky bypass request.
// The reset_unit command releases only the channels whose fault has gone away.
module fault_latch_nch #(
  parameter int N_CH       = 12,
  parameter int CNT_W      = 14,
  parameter int BYP_W      = 20,
  parameter int BYP_DLY_US = 1000,
  localparam int IDX_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             time_1us,
  input  logic             reset_unit,
  input  logic [N_CH-1:0]  fault_in,
  input  logic [N_CH-1:0]  fault_mask,
  input  logic [CNT_W-1:0] dly_us,
  output logic [N_CH-1:0]  err_info,
  output logic             err_unit,
  output logic             trip,
  output logic [IDX_W-1:0] first_idx,
  output logic             first_valid,
  output logic [7:0]       trip_cnt,
  output logic             byp_req
);

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    TRIP   = 2'd1,
    CLEAR  = 2'd2
  } state_t;

  localparam logic [BYP_W-1:0] BYP_LIMIT = BYP_W'(BYP_DLY_US);

  state_t           state;
  logic [CNT_W-1:0] cnt      [N_CH];
  logic [CNT_W-1:0] cnt_next [N_CH];
  logic [N_CH-1:0]  eff;
  logic [N_CH-1:0]  new_lat;
  logic [N_CH-1:0]  clr_ok;
  logic [N_CH-1:0]  err_set;
  logic [N_CH-1:0]  err_cleared;
  logic [N_CH-1:0]  first_new;
  logic [IDX_W-1:0] first_new_idx;
  logic [CNT_W-1:0] thr;
  logic [BYP_W-1:0] byp_cnt;
  logic [BYP_W-1:0] byp_inc;
  logic             byp_hit;

  // Debounce arithmetic: next counter values, new latches, clear eligibility, first index.
  always_comb begin
    // NOTE: every signal gets a default before any conditional update, so no latch is inferred.
    thr           = (dly_us == '0) ? CNT_W'(1) : dly_us;
    eff           = fault_in & ~fault_mask;
    new_lat       = '0;
    clr_ok        = '0;
    first_new_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_next[i] = cnt[i];
      if (!eff[i]) begin
        cnt_next[i] = '0;
      end else if (time_1us && (cnt[i] != '1)) begin
        cnt_next[i] = cnt[i] + CNT_W'(1);
      end
      new_lat[i] = eff[i] && (cnt_next[i] >= thr);
      clr_ok[i]  = !eff[i] && (cnt[i] == '0);
    end
    err_set     = err_info | new_lat;
    err_cleared = (err_info & ~clr_ok) | new_lat;
    first_new   = new_lat & ~err_info;
    // Scan downwards so that the lowest newly set channel is the one kept.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (first_new[i]) first_new_idx = IDX_W'(i);
    end
    byp_inc = (byp_cnt == BYP_LIMIT) ? byp_cnt : byp_cnt + BYP_W'(1);
    byp_hit = time_1us && (byp_inc == BYP_LIMIT);
  end

  // Per-channel debounce counters.
  always_ff @(posedge clk) begin
    // NOTE: the counters are ordinary flops, not a memory, so they take the reset like any other state.
    if (rst) begin
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) cnt[i] <= cnt_next[i];
    end
  end

  // Trip FSM with registered outputs, the bypass timer and the trip statistics.
  always_ff @(posedge clk) begin
    // NOTE: all state in this block uses non-blocking assignments so it updates together at the edge.
    if (rst) begin
      state       <= NORMAL;
      err_info    <= '0;
      err_unit    <= 1'b0;
      trip        <= 1'b0;
      first_idx   <= '0;
      first_valid <= 1'b0;
      trip_cnt    <= '0;
      byp_cnt     <= '0;
      byp_req     <= 1'b0;
    end else begin
      trip     <= 1'b0;
      err_info <= err_set;
      err_unit <= |err_info;
      case (state)
        NORMAL: begin
          if (|err_set) begin
            state       <= TRIP;
            trip        <= 1'b1;
            first_idx   <= first_new_idx;
            first_valid <= 1'b1;
            if (trip_cnt != 8'hFF) trip_cnt <= trip_cnt + 8'd1;
          end
        end
        TRIP: begin
          if (time_1us) byp_cnt <= byp_inc;
          if (byp_hit) byp_req <= 1'b1;
          if (reset_unit) state <= CLEAR;
        end
        CLEAR: begin
          err_info <= err_cleared;
          if (err_cleared == '0) begin
            state       <= NORMAL;
            first_valid <= 1'b0;
            byp_cnt     <= '0;
          end else begin
            state <= TRIP;
            if (time_1us) byp_cnt <= byp_inc;
            if (byp_hit) byp_req <= 1'b1;
          end
        end
        default: state <= NORMAL;
      endcase
    end
  end

endmodule

// File: tb/tb_fault_latch_nch.sv
// Directed self-checking bench for fault_latch_nch with the default parameters.
// One stimulus table covers the basic latch and clear path.
// Hand-written sequences cover the multi-cycle corner cases.
module tb_fault_latch_nch;

  logic        clk = 1'b0;
  logic        rst;
  logic        time_1us;
  logic        reset_unit;
  logic [11:0] fault_in;
  logic [11:0] fault_mask;
  logic [13:0] dly_us;
  logic [11:0] err_info;
  logic        err_unit;
  logic        trip;
  logic [3:0]  first_idx;
  logic        first_valid;
  logic [7:0]  trip_cnt;
  logic        byp_req;

  int n_chk = 0;
  int n_err = 0;
  int n_trips;

  typedef struct {
    logic [11:0] fin;
    logic        tick;
    logic        ru;
    logic [11:0] e_err;
    logic        e_trip;
    logic        e_unit;
    logic        e_fv;
    logic [3:0]  e_idx;
    logic [7:0]  e_tcnt;
  } vec_t;

  vec_t tbl [9];

  fault_latch_nch dut (
    .clk         (clk),
    .rst         (rst),
    .time_1us    (time_1us),
    .reset_unit  (reset_unit),
    .fault_in    (fault_in),
    .fault_mask  (fault_mask),
    .dly_us      (dly_us),
    .err_info    (err_info),
    .err_unit    (err_unit),
    .trip        (trip),
    .first_idx   (first_idx),
    .first_valid (first_valid),
    .trip_cnt    (trip_cnt),
    .byp_req     (byp_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock; outputs are read 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    fault_in   = '0;
    time_1us   = 1'b0;
    cyc();
    reset_unit = 1'b1;
    cyc();
    reset_unit = 1'b0;
    cyc();
  endtask

  task automatic check_all_zero(input string name);
    check(name, {20'd0, err_info}, 32'd0);
    check({name, "_flags"}, {28'd0, err_unit, trip, first_valid, byp_req}, 32'd0);
    check({name, "_tcnt"}, {24'd0, trip_cnt}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    time_1us   = 1'b0;
    reset_unit = 1'b0;
    fault_in   = '0;
    fault_mask = '0;
    dly_us     = 14'd5;
    cyc();
    cyc();
    check_all_zero("reset");
    rst = 1'b0;

    // Latch at threshold through the table: dly_us = 5, channel 3, one tick per cycle.
    for (int i = 0; i < 4; i++) tbl[i] = '{12'h008, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
    tbl[4] = '{12'h008, 1'b1, 1'b0, 12'h008, 1'b1, 1'b0, 1'b1, 4'd3, 8'd1};
    tbl[5] = '{12'h008, 1'b0, 1'b0, 12'h008, 1'b0, 1'b1, 1'b1, 4'd3, 8'd1};
    tbl[6] = '{12'h000, 1'b0, 1'b1, 12'h008, 1'b0, 1'b1, 1'b1, 4'd3, 8'd1};
    tbl[7] = '{12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 4'd0, 8'd1};
    tbl[8] = '{12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1};
    for (int i = 0; i < 9; i++) begin
      fault_in   = tbl[i].fin;
      time_1us   = tbl[i].tick;
      reset_unit = tbl[i].ru;
      cyc();
      check($sformatf("tbl%0d_err", i), {20'd0, err_info}, {20'd0, tbl[i].e_err});
      check($sformatf("tbl%0d_trip", i), {31'd0, trip}, {31'd0, tbl[i].e_trip});
      check($sformatf("tbl%0d_unit", i), {31'd0, err_unit}, {31'd0, tbl[i].e_unit});
      check($sformatf("tbl%0d_fv", i), {31'd0, first_valid}, {31'd0, tbl[i].e_fv});
      check($sformatf("tbl%0d_tcnt", i), {24'd0, trip_cnt}, {24'd0, tbl[i].e_tcnt});
      if (tbl[i].e_fv) check($sformatf("tbl%0d_idx", i), {28'd0, first_idx}, {28'd0, tbl[i].e_idx});
    end
    reset_unit = 1'b0;

    // Glitch rejection: 9 ticks, one low cycle, 9 ticks against a threshold of 10.
    dly_us   = 14'd10;
    time_1us = 1'b1;
    n_trips  = 0;
    for (int i = 0; i < 19; i++) begin
      fault_in = (i == 9) ? 12'h000 : 12'h001;
      cyc();
      if (trip) n_trips++;
    end
    check("glitch_err", {20'd0, err_info}, 32'd0);
    check("glitch_trips", n_trips, 0);
    fault_in = '0;
    time_1us = 1'b0;
    cyc();

    // First-fault priority: channels 7 and 2 together, channel 0 later.
    dly_us   = 14'd3;
    time_1us = 1'b1;
    fault_in = 12'h084;
    cyc();
    cyc();
    check("prio_early", {20'd0, err_info}, 32'd0);
    cyc();
    check("prio_err1", {20'd0, err_info}, 32'h084);
    check("prio_trip", {31'd0, trip}, 32'd1);
    check("prio_idx1", {28'd0, first_idx}, 32'd2);
    fault_in = 12'h085;
    n_trips  = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (trip) n_trips++;
    end
    check("prio_err2", {20'd0, err_info}, 32'h085);
    check("prio_idx2", {28'd0, first_idx}, 32'd2);
    check("prio_no_retrip", n_trips, 0);
    check("prio_tcnt", {24'd0, trip_cnt}, 32'd2);
    do_clear();
    check("prio_cleared", {20'd0, err_info}, 32'd0);

    // Clear with a persistent fault on channel 4.
    dly_us   = 14'd2;
    time_1us = 1'b1;
    fault_in = 12'h012;
    cyc();
    cyc();
    check("pers_err", {20'd0, err_info}, 32'h012);
    check("pers_idx", {28'd0, first_idx}, 32'd1);
    time_1us   = 1'b0;
    fault_in   = 12'h010;
    cyc();
    reset_unit = 1'b1;
    cyc();
    reset_unit = 1'b0;
    cyc();
    check("pers_keep", {20'd0, err_info}, 32'h010);
    check("pers_no_trip", {31'd0, trip}, 32'd0);
    check("pers_fv", {31'd0, first_valid}, 32'd1);
    cyc();
    check("pers_no_trip2", {31'd0, trip}, 32'd0);
    check("pers_tcnt", {24'd0, trip_cnt}, 32'd3);
    check("pers_idx_kept", {28'd0, first_idx}, 32'd1);
    do_clear();
    check("pers_all_clear", {20'd0, err_info}, 32'd0);
    check("pers_fv_clear", {31'd0, first_valid}, 32'd0);

    // Bypass timeout: trip, then 1000 ticks while tripped.
    dly_us   = 14'd1;
    time_1us = 1'b1;
    fault_in = 12'h001;
    cyc();
    check("byp_trip", {31'd0, trip}, 32'd1);
    for (int i = 0; i < 999; i++) cyc();
    check("byp_before", {31'd0, byp_req}, 32'd0);
    cyc();
    check("byp_at_limit", {31'd0, byp_req}, 32'd1);
    do_clear();
    check("byp_cleared_err", {20'd0, err_info}, 32'd0);
    check("byp_sticky", {31'd0, byp_req}, 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_all_zero("byp_rst");

    // A masked channel never latches.
    dly_us     = 14'd2;
    time_1us   = 1'b1;
    fault_mask = 12'h020;
    fault_in   = 12'h020;
    n_trips    = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (trip) n_trips++;
    end
    check("mask_err", {20'd0, err_info}, 32'd0);
    check("mask_trips", n_trips, 0);
    fault_mask = '0;
    fault_in   = '0;
    cyc();

    // rst mid-count restarts the debounce from zero.
    dly_us   = 14'd8;
    fault_in = 12'h040;
    for (int i = 0; i < 4; i++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_all_zero("midrst");
    for (int i = 0; i < 7; i++) cyc();
    check("midrst_restart", {20'd0, err_info}, 32'd0);
    cyc();
    check("midrst_latch", {20'd0, err_info}, 32'h040);
    rst = 1'b1;
    fault_in = '0;
    cyc();
    rst = 1'b0;

    // trip_cnt saturates at 255 over 300 trip/clear rounds.
    dly_us = 14'd1;
    for (int i = 0; i < 300; i++) begin
      fault_in = 12'h001;
      time_1us = 1'b1;
      cyc();
      if (i == 0) check("sat_first", {24'd0, trip_cnt}, 32'd1);
      do_clear();
    end
    check("sat_tcnt", {24'd0, trip_cnt}, 32'd255);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
